// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the RMII transmit path.
//   RMII_DIBITS_PER_OCTET : dibits needed to carry one octet on RMII
//   RMII_10M_REPEAT       : clocks each dibit is held at 10 Mb/s
//   ETH_IPG_OCTETS        : default minimum inter-packet gap in octets
//   rmii_tx_state_t       : transmit serialiser states
package eth_pkg;

    localparam int unsigned RMII_DIBITS_PER_OCTET = 4;
    localparam int unsigned RMII_10M_REPEAT       = 10;
    localparam int unsigned ETH_IPG_OCTETS        = 12;

    typedef enum logic [1:0] {
        IDLE,
        TX,
        DRAIN,
        IPG
    } rmii_tx_state_t;

endpackage

// File: rtl/eth_rmii_tx.sv
// RMII transmit serialiser. Takes a complete byte-wide frame stream (preamble to FCS)
// and shifts it out LSB-first as dibits, one per clock at 100 Mb/s or each held for
// ten clocks at 10 Mb/s. Enforces the inter-packet gap and flags input starvation
// mid-frame as an underrun, after which the rest of the frame is discarded.
// Ports:
//   clk, sresetn          : 50 MHz RMII reference clock, synchronous active-low reset
//   speed_10              : 1 = 10 Mb/s, sampled when a frame's first byte is accepted
//   axis_i_*              : byte stream input (tready/tvalid/tlast/tdata)
//   rmii_txd, rmii_tx_en  : registered PHY transmit pins
//   underrun              : one-cycle pulse on mid-frame starvation
module eth_rmii_tx
    import eth_pkg::*;
#(
    parameter int unsigned IPG_OCTETS = ETH_IPG_OCTETS
) (
    input  logic       clk,
    input  logic       sresetn,
    input  logic       speed_10,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    output logic [1:0] rmii_txd,
    output logic       rmii_tx_en,
    output logic       underrun
);

    // Sized for the slowest rate so the counter can reach the full 10 Mb/s gap.
    localparam int unsigned IpgMax = IPG_OCTETS * RMII_DIBITS_PER_OCTET * RMII_10M_REPEAT;
    localparam int unsigned IpgW   = (IpgMax < 2) ? 1 : $clog2(IpgMax + 1);

    rmii_tx_state_t  state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic            last_q, last_d;
    logic [3:0]      rep_q, rep_d;
    logic [1:0]      dibit_cnt_q, dibit_cnt_d;
    logic [3:0]      rep_cnt_q, rep_cnt_d;
    logic [IpgW-1:0] ipg_cnt_q, ipg_cnt_d;
    logic [1:0]      txd_q, txd_d;
    logic            tx_en_q, tx_en_d;
    logic            underrun_q, underrun_d;

    logic            rep_last;
    logic            byte_end;
    logic            handshake;
    logic [IpgW-1:0] ipg_last;

    assign rep_last  = (rep_cnt_q == (rep_q - 4'd1));
    assign byte_end  = (state_q == TX) && (dibit_cnt_q == 2'd3) && rep_last;
    assign handshake = axis_i_tvalid && axis_i_tready;
    // Gap length follows the rate latched for the frame just sent.
    assign ipg_last  = IpgW'((IPG_OCTETS * RMII_DIBITS_PER_OCTET) * {28'd0, rep_q} - 1);

    // Ready depends only on state and counters so upstream never sees a loop through tvalid.
    always_comb begin
        axis_i_tready = 1'b0;
        if (sresetn) begin
            unique case (state_q)
                IDLE:    axis_i_tready = 1'b1;
                DRAIN:   axis_i_tready = 1'b1;
                TX:      axis_i_tready = byte_end && !last_q;
                default: axis_i_tready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        last_d      = last_q;
        rep_d       = rep_q;
        dibit_cnt_d = dibit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        ipg_cnt_d   = ipg_cnt_q;
        underrun_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    byte_d      = axis_i_tdata;
                    last_d      = axis_i_tlast;
                    rep_d       = speed_10 ? 4'(RMII_10M_REPEAT) : 4'd1;
                    dibit_cnt_d = 2'd0;
                    rep_cnt_d   = 4'd0;
                    state_d     = TX;
                end
            end
            TX: begin
                if (byte_end) begin
                    dibit_cnt_d = 2'd0;
                    rep_cnt_d   = 4'd0;
                    if (last_q) begin
                        state_d   = IPG;
                        ipg_cnt_d = '0;
                    end else if (axis_i_tvalid) begin
                        byte_d = axis_i_tdata;
                        last_d = axis_i_tlast;
                    end else begin
                        // RMII cannot stall: abandon the frame and swallow the rest of it.
                        state_d    = DRAIN;
                        underrun_d = 1'b1;
                    end
                end else if (rep_last) begin
                    rep_cnt_d   = 4'd0;
                    dibit_cnt_d = dibit_cnt_q + 2'd1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                if (handshake && axis_i_tlast) begin
                    state_d   = IPG;
                    ipg_cnt_d = '0;
                end
            end
            IPG: begin
                if (ipg_cnt_q == ipg_last) begin
                    state_d   = IDLE;
                    ipg_cnt_d = '0;
                end else begin
                    ipg_cnt_d = ipg_cnt_q + {{(IpgW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from next-state values so tx_en rises the cycle after
        // the first-byte handshake already carrying tdata[1:0].
        tx_en_d = (state_d == TX);
        txd_d   = tx_en_d ? byte_d[{dibit_cnt_d, 1'b0} +: 2] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q     <= IDLE;
            byte_q      <= 8'd0;
            last_q      <= 1'b0;
            rep_q       <= 4'd1;
            dibit_cnt_q <= 2'd0;
            rep_cnt_q   <= 4'd0;
            ipg_cnt_q   <= '0;
            txd_q       <= 2'b00;
            tx_en_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            rep_q       <= rep_d;
            dibit_cnt_q <= dibit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            ipg_cnt_q   <= ipg_cnt_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            underrun_q  <= underrun_d;
        end
    end

    assign rmii_txd   = txd_q;
    assign rmii_tx_en = tx_en_q;
    assign underrun   = underrun_q;

endmodule
